// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART frame receiver with optional parity and framing checks
//
// Purpose: deserialises one UART frame (start, DATA_W data bits LSB first,
// optional parity, one stop bit) from an already-synchronous serial line.
// Optional build macro: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling
// around mid-bit; when undefined a single mid-bit sample is used.
//
// Ports:
//   CLK        in   single clock, rising edge
//   RST        in   synchronous active-high reset
//   RX_IN      in   serial line, idle high
//   Prescale   in   CLK cycles per bit (bit 0 ignored, minimum 8)
//   PAR_en     in   1 = parity bit present
//   PAR_TYP    in   0 = even, 1 = odd parity
//   data_out   out  last accepted byte
//   data_valid out  one-cycle pulse, frame accepted
//   par_err    out  one-cycle pulse, parity mismatch
//   stop_err   out  one-cycle pulse, stop bit sampled 0
//   busy       out  high whenever not idle
module uart_rx_ctrl #(
  parameter int PRESCALE_W = 6,
  parameter int DATA_W     = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_en,
  input  logic                  PAR_TYP,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err,
  output logic                  busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] p_reg;
  logic [PRESCALE_W-1:0] p_even;
  logic [PRESCALE_W-1:0] p_eff;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_W-1:0]     shift_reg;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic                  par_bad;
  logic                  bit_val;
  logic                  start_pend;
`ifdef UART_RX_MAJORITY_EN
  logic                  s0;
  logic                  s1;
  logic [PRESCALE_W-1:0] half_m1;
  logic [PRESCALE_W-1:0] half_p1;

  assign half_m1 = half - PRESCALE_W'(1);
  assign half_p1 = half + PRESCALE_W'(1);
`endif

  // Odd prescale rounds down to even; anything under 8 is clamped to 8 so the
  // sample points always sit strictly inside the bit.
  always_comb begin
    p_even = Prescale & ~PRESCALE_W'(1);
    p_eff  = (p_even < PRESCALE_W'(8)) ? PRESCALE_W'(8) : p_even;
  end

  assign half = p_reg >> 1;
  assign last = p_reg - PRESCALE_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      p_reg      <= PRESCALE_W'(8);
      shift_reg  <= '0;
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      par_bad    <= 1'b0;
      bit_val    <= 1'b1;
      start_pend <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s0         <= 1'b1;
      s1         <= 1'b1;
`endif
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;

      // Bit value is settled well before edge_cnt reaches the last count.
      if (state != IDLE) begin
`ifdef UART_RX_MAJORITY_EN
        if (edge_cnt == half_m1) s0 <= RX_IN;
        if (edge_cnt == half) s1 <= RX_IN;
        if (edge_cnt == half_p1) bit_val <= (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
`else
        if (edge_cnt == half) bit_val <= RX_IN;
`endif
      end

      if (state == IDLE) begin
        // start_pend means the next start bit already began on the last edge
        // of STOP, so that edge counts as this frame's first cycle.
        if (!RX_IN || start_pend) begin
          state      <= START;
          busy       <= 1'b1;
          edge_cnt   <= start_pend ? PRESCALE_W'(1) : '0;
          start_pend <= 1'b0;
          p_reg      <= p_eff;
          par_en_r   <= PAR_en;
          par_typ_r  <= PAR_TYP;
          par_bad    <= 1'b0;
        end
      end else if (edge_cnt != last) begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end else begin
        edge_cnt <= '0;
        case (state)
          START: begin
            if (bit_val) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg[bit_cnt] <= bit_val;
            if (bit_cnt == BW'(DATA_W - 1)) begin
              state <= par_en_r ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          PARITY: begin
            par_bad <= bit_val != ((^shift_reg) ^ par_typ_r);
            state   <= STOP;
          end
          STOP: begin
            state      <= IDLE;
            busy       <= 1'b0;
            start_pend <= !RX_IN;
            if (!par_bad && bit_val) begin
              data_valid <= 1'b1;
              data_out   <= shift_reg;
            end else begin
              par_err  <= par_bad;
              stop_err <= !bit_val;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_en;
  logic       PAR_TYP;
  logic [7:0] data_out;
  logic       data_valid;
  logic       par_err;
  logic       stop_err;
  logic       busy;

  uart_rx_ctrl #(.PRESCALE_W(6), .DATA_W(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_en(PAR_en), .PAR_TYP(PAR_TYP), .data_out(data_out),
    .data_valid(data_valid), .par_err(par_err), .stop_err(stop_err),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] flags;   // {data_valid, par_err, stop_err}
    logic [7:0] data;
    int         edge_no; // rising edge that registers the pulse
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse is matched against the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && (data_valid || par_err || stop_err)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {29'd0, data_valid, par_err, stop_err}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_flags", {29'd0, data_valid, par_err, stop_err}, {29'd0, e.flags});
        check("pulse_data_out", {24'd0, data_out}, {24'd0, e.data});
        check("pulse_cycle", cyc, e.edge_no);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives one frame cycle by cycle; glitch (>=0) inverts the line for the
  // single cycle seen at edge E0+glitch.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic sbit, input int len, input int glitch,
                            input logic [2:0] exp_flags, input logic [7:0] exp_data);
    logic [10:0] bits;
    int          nbits;
    exp_t        e;
    nbits = pen ? 11 : 10;
    bits  = pen ? {sbit, pbit, d, 1'b0} : {1'b0, sbit, d, 1'b0};
    e.flags   = exp_flags;
    e.data    = exp_data;
    e.edge_no = cyc + 1 + nbits * len;
    q.push_back(e);
    for (int c = 0; c < nbits * len; c++) begin
      RX_IN = bits[c / len] ^ (c == glitch);
      tick(1);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick(1);
      n++;
    end
    check(name, {31'd0, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_en = 1'b0; PAR_TYP = 1'b0;
    tick(2);
    check("rst_data_out", {24'd0, data_out}, 0);
    check("rst_data_valid", {31'd0, data_valid}, 0);
    check("rst_par_err", {31'd0, par_err}, 0);
    check("rst_stop_err", {31'd0, stop_err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    RST = 1'b0;
    tick(3);

    // Even parity, 0xA5 has four ones -> parity 0: accepted at E0+88.
    PAR_en = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8, -1, 3'b100, 8'hA5);
    RX_IN = 1'b1; tick(4);

    // Odd parity, 0x0F four ones -> parity 1: accepted.
    PAR_TYP = 1'b1;
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 8, -1, 3'b100, 8'h0F);
    RX_IN = 1'b1; tick(4);

    // Odd parity, 0xA5 with parity 0: par_err, data_out keeps 0x0F.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8, -1, 3'b010, 8'h0F);
    RX_IN = 1'b1; tick(4);

    // Prescale 16, no parity, stop bit 0: stop_err at E0+160.
    Prescale = 6'd16; PAR_en = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 16, -1, 3'b001, 8'h0F);
    RX_IN = 1'b1; tick(2);
    wait_idle("busy_after_stop_err");

    // Even parity, 0x03 with parity 1 and stop 0: both errors together.
    Prescale = 6'd8; PAR_en = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'h03, 1'b1, 1'b1, 1'b0, 8, -1, 3'b011, 8'h0F);
    RX_IN = 1'b1; tick(2);
    wait_idle("busy_after_both_err");

    // Two-cycle low glitch in IDLE: start aborts, busy clears within 8 cycles.
    PAR_en = 1'b0;
    RX_IN = 1'b0; tick(2);
    RX_IN = 1'b1; tick(1);
    check("glitch_busy_high", {31'd0, busy}, 1);
    tick(7);
    check("glitch_busy_low", {31'd0, busy}, 0);
    tick(4);

    // Odd Prescale 9 behaves as 8.
    Prescale = 6'd9;
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 8, -1, 3'b100, 8'h96);
    RX_IN = 1'b1; tick(4);

    // Prescale 2 is clamped to 8; a glitch away from the sample point is ignored.
    Prescale = 6'd2;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8, 9, 3'b100, 8'h5A);
    RX_IN = 1'b1; tick(4);

    // Back-to-back frames: pulses exactly 80 cycles apart.
    Prescale = 6'd8;
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 8, -1, 3'b100, 8'h01);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 8, -1, 3'b100, 8'hFE);
    RX_IN = 1'b1; tick(4);

    // Reset during DATA of 0x55 (start + bits 1,0,1 sent).
    RX_IN = 1'b0; tick(8);
    RX_IN = 1'b1; tick(8);
    RX_IN = 1'b0; tick(8);
    RX_IN = 1'b1; tick(3);
    RST = 1'b1; tick(1);
    check("midrst_data_out", {24'd0, data_out}, 0);
    check("midrst_pulses", {29'd0, data_valid, par_err, stop_err}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    RST = 1'b0;
    tick(100);
    check("postrst_busy", {31'd0, busy}, 0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 8, -1, 3'b100, 8'h55);
    RX_IN = 1'b1; tick(4);

`ifdef UART_RX_MAJORITY_EN
    // Single-cycle low at the mid-bit sample of data bit 2 is outvoted.
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 8, 29, 3'b100, 8'hFF);
    RX_IN = 1'b1; tick(4);
`endif

    for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
    check("scoreboard_drained", q.size(), 0);
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
